// File: rtl/cpu_pkg.sv
// Shared types and helpers for the bit-serial CPU front end.
//   loader_state_t : instruction loader FSM states
//   clog2          : ceiling log2 for deriving counter and index widths
package cpu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_HOLD = 2'd2
   } loader_state_t;

   // Smallest r such that 2**r >= v; returns 0 for v <= 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((33'd1 << i) < 33'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchroniser, debounce filter and rising-edge detector.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   btn_in     : raw asynchronous button, active high
//   press      : registered 1-cycle pulse on each debounced rising edge
module btn_conditioner
   import cpu_pkg::*;
#(
   parameter int unsigned SYNC_STG  = 2,
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic press
);

   localparam int unsigned CNT_W = (clog2(DB_CYCLES + 1) < 1) ? 1 : clog2(DB_CYCLES + 1);

   logic [SYNC_STG-1:0] r_sync;
   logic                w_synced;
   logic                w_filt;
   logic                r_filt_q;
   logic                r_press;

   // Metastability synchroniser.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= '0;
      else        r_sync <= {r_sync[SYNC_STG-2:0], btn_in};
   end

   assign w_synced = r_sync[SYNC_STG-1];

   generate
      if (DB_CYCLES == 0) begin : g_no_db
         assign w_filt = w_synced;
      end else begin : g_db
         logic [CNT_W-1:0] r_cnt;
         logic             r_filt;

         // Filtered level follows the synced level only after DB_CYCLES consecutive disagreeing cycles.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cnt  <= '0;
               r_filt <= 1'b0;
            end else if (w_synced != r_filt) begin
               if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
                  r_filt <= w_synced;
                  r_cnt  <= '0;
               end else begin
                  r_cnt  <= r_cnt + CNT_W'(1);
               end
            end else begin
               r_cnt <= '0;
            end
         end

         assign w_filt = r_filt;
      end
   endgenerate

   // Rising-edge detect; releases never pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_filt_q <= 1'b0;
         r_press  <= 1'b0;
      end else begin
         r_filt_q <= w_filt;
         r_press  <= w_filt & ~r_filt_q;
      end
   end

   assign press = r_press;

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: assembles an INSTR_W-bit instruction from IN_W-bit switch chunks,
// one chunk per conditioned button press, and offers it to the core over valid/ready.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   sw_in        : switch chunk captured on each press
//   btn_in       : raw push button
//   clr_in       : synchronous abort of partial or held instruction
//   instr_valid  : complete instruction held
//   instr_ready  : core accepts instruction
//   opcode       : instr[OPC_W-1:0]
//   operand      : instr[INSTR_W-1:OPC_W]
//   beat_idx     : index of next chunk expected
//   overrun      : sticky, press arrived while an instruction was held
module instr_loader
   import cpu_pkg::*;
#(
   parameter  int unsigned IN_W      = 8,
   parameter  int unsigned INSTR_W   = 16,
   parameter  int unsigned OPC_W     = 4,
   parameter  int unsigned SYNC_STG  = 2,
   parameter  int unsigned DB_CYCLES = 4,
   localparam int unsigned BEATS     = (INSTR_W + IN_W - 1) / IN_W,
   localparam int unsigned BEAT_W    = (BEATS <= 1) ? 1 : clog2(BEATS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [IN_W-1:0]          sw_in,
   input  logic                     btn_in,
   input  logic                     clr_in,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   output logic [OPC_W-1:0]         opcode,
   output logic [INSTR_W-OPC_W-1:0] operand,
   output logic [BEAT_W-1:0]        beat_idx,
   output logic                     overrun
);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   loader_state_t       r_state;
   loader_state_t       w_state_nx;
   logic [INSTR_W-1:0]  r_buf;
   logic [INSTR_W-1:0]  w_buf_nx;
   logic [BEAT_W-1:0]   r_beat;
   logic [BEAT_W-1:0]   w_beat_nx;
   logic                r_valid;
   logic                w_valid_nx;
   logic                r_ovr;
   logic                w_ovr_nx;
   logic                w_press;
   logic                w_xfer;
   logic                w_last;
   logic                w_capture;

   btn_conditioner #(
      .SYNC_STG  (SYNC_STG),
      .DB_CYCLES (DB_CYCLES)
   ) u_btn (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_in (btn_in),
      .press  (w_press)
   );

   assign w_xfer = r_valid & instr_ready;
   assign w_last = (r_beat == LAST_BEAT);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   // Next-state logic; clr_in overrides presses and transfers.
   always_comb begin
      w_state_nx = r_state;
      if (clr_in) begin
         w_state_nx = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE:  if (w_press)           w_state_nx = (BEATS == 1) ? S_HOLD : S_FILL;
            S_FILL:  if (w_press && w_last) w_state_nx = S_HOLD;
            S_HOLD:  if (w_xfer)            w_state_nx = S_IDLE;
            default:                        w_state_nx = S_IDLE;
         endcase
      end
   end

   // Datapath next values: chunk capture, beat counter, overrun flag.
   always_comb begin
      w_buf_nx  = r_buf;
      w_beat_nx = r_beat;
      w_ovr_nx  = r_ovr;
      w_capture = 1'b0;
      if (clr_in) begin
         w_buf_nx  = '0;
         w_beat_nx = '0;
         w_ovr_nx  = 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE, S_FILL: begin
               if (w_press) begin
                  w_capture = 1'b1;
                  w_beat_nx = w_last ? '0 : r_beat + BEAT_W'(1);
               end
            end
            S_HOLD:  if (w_press) w_ovr_nx = 1'b1;
            default: ;
         endcase
         // Bits of the last chunk beyond INSTR_W fall outside the loop and are dropped.
         if (w_capture) begin
            for (int i = 0; i < int'(INSTR_W); i++) begin
               if (BEAT_W'(i / int'(IN_W)) == r_beat) w_buf_nx[i] = sw_in[i % int'(IN_W)];
            end
         end
      end
      w_valid_nx = (w_state_nx == S_HOLD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf   <= '0;
         r_beat  <= '0;
         r_valid <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_buf   <= w_buf_nx;
         r_beat  <= w_beat_nx;
         r_valid <= w_valid_nx;
         r_ovr   <= w_ovr_nx;
      end
   end

   assign instr_valid = r_valid;
   assign opcode      = r_buf[OPC_W-1:0];
   assign operand     = r_buf[INSTR_W-1:OPC_W];
   assign beat_idx    = r_beat;
   assign overrun     = r_ovr;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: three instances (INSTR_W = 16, 12, 8) share one stimulus stream.
// A per-instance reference model queues expected instructions; a monitor pops on each transfer.
module tb_instr_loader;

   localparam int ND = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] sw_in = 8'h00;
   logic       btn_in = 1'b0;
   logic       clr_in = 1'b0;
   logic       instr_ready = 1'b0;

   logic        v16, v12, v8;
   logic [3:0]  opc16, opc12, opc8;
   logic [11:0] opr16;
   logic [7:0]  opr12;
   logic [3:0]  opr8;
   logic        b16, b12, b8;
   logic        o16, o12, o8;

   always #5 clk = ~clk;

   instr_loader #(.IN_W(8), .INSTR_W(16), .OPC_W(4), .SYNC_STG(2), .DB_CYCLES(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .btn_in(btn_in), .clr_in(clr_in),
      .instr_valid(v16), .instr_ready(instr_ready), .opcode(opc16), .operand(opr16),
      .beat_idx(b16), .overrun(o16));

   instr_loader #(.IN_W(8), .INSTR_W(12), .OPC_W(4), .SYNC_STG(2), .DB_CYCLES(4)) u_dut12 (
      .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .btn_in(btn_in), .clr_in(clr_in),
      .instr_valid(v12), .instr_ready(instr_ready), .opcode(opc12), .operand(opr12),
      .beat_idx(b12), .overrun(o12));

   instr_loader #(.IN_W(8), .INSTR_W(8), .OPC_W(4), .SYNC_STG(2), .DB_CYCLES(4)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .btn_in(btn_in), .clr_in(clr_in),
      .instr_valid(v8), .instr_ready(instr_ready), .opcode(opc8), .operand(opr8),
      .beat_idx(b8), .overrun(o8));

   logic [15:0] act_instr[ND];
   logic        act_valid[ND];
   logic        act_beat[ND];
   logic        act_ovr[ND];

   assign act_instr[0] = {opr16, opc16};
   assign act_instr[1] = {4'h0, opr12, opc12};
   assign act_instr[2] = {8'h00, opr8, opc8};
   assign act_valid[0] = v16;
   assign act_valid[1] = v12;
   assign act_valid[2] = v8;
   assign act_beat[0]  = b16;
   assign act_beat[1]  = b12;
   assign act_beat[2]  = b8;
   assign act_ovr[0]   = o16;
   assign act_ovr[1]   = o12;
   assign act_ovr[2]   = o8;

   // Reference model: chunks per instruction and instruction mask per instance.
   int          nbeats[ND] = '{2, 2, 1};
   logic [15:0] imask[ND]  = '{16'hFFFF, 16'h0FFF, 16'h00FF};
   logic [15:0] exp_q[ND][$];
   int          cnt[ND];
   logic [15:0] acc[ND];
   bit          held[ND];
   bit          ovr_exp[ND];
   bit          chk_low[ND];

   int n_checks = 0;
   int n_err    = 0;
   int ready_mode = 0;   // 0: ready low, 1: ready high, 2: random
   logic [15:0] mon_e;

   task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d act=0x%0h exp=0x%0h t=%0t", name, d, act, exp, $time);
      end
   endtask

   task automatic model_press(input logic [7:0] sw);
      for (int d = 0; d < ND; d++) begin
         if (held[d]) begin
            ovr_exp[d] = 1'b1;
         end else begin
            acc[d] = acc[d] | (16'(sw) << (8 * cnt[d]));
            cnt[d]++;
            if (cnt[d] == nbeats[d]) begin
               exp_q[d].push_back(acc[d] & imask[d]);
               held[d] = 1'b1;
               cnt[d]  = 0;
               acc[d]  = '0;
            end
         end
      end
   endtask

   task automatic model_clear();
      for (int d = 0; d < ND; d++) begin
         cnt[d]     = 0;
         acc[d]     = '0;
         held[d]    = 1'b0;
         ovr_exp[d] = 1'b0;
         chk_low[d] = 1'b0;
         exp_q[d].delete();
      end
   endtask

   // Hold the button for 'hold' cycles, then release long enough for the debouncer to settle.
   task automatic press(input logic [7:0] sw, input int hold, input bit modeled);
      @(posedge clk); #1;
      sw_in = sw;
      if (modeled) model_press(sw);
      btn_in = 1'b1;
      repeat (hold) @(posedge clk);
      #1 btn_in = 1'b0;
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag);
      for (int d = 0; d < ND; d++) begin
         check({tag, "_beat"},  d, 32'(act_beat[d]),  32'(cnt[d]));
         check({tag, "_ovr"},   d, 32'(act_ovr[d]),   32'(ovr_exp[d]));
         check({tag, "_valid"}, d, 32'(act_valid[d]), 32'(held[d]));
      end
   endtask

   task automatic check_reset(input string tag);
      for (int d = 0; d < ND; d++) begin
         check({tag, "_valid"}, d, 32'(act_valid[d]), 32'd0);
         check({tag, "_beat"},  d, 32'(act_beat[d]),  32'd0);
         check({tag, "_ovr"},   d, 32'(act_ovr[d]),   32'd0);
         check({tag, "_instr"}, d, 32'(act_instr[d]), 32'd0);
      end
   endtask

   task automatic wait_drain();
      int t;
      int left;
      t = 0;
      left = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
      while (left != 0 && t < 300) begin
         @(posedge clk); #1;
         t++;
         left = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
      end
      if (left != 0) begin
         check("drain_timeout", 0, 32'(left), 32'd0);
         model_clear();
      end
   endtask

   // Ready driver.
   initial begin
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       instr_ready = 1'b0;
            1:       instr_ready = 1'b1;
            default: instr_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: every accepted instruction must match the head of that instance's queue,
   // and valid must drop on the cycle after the transfer.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < ND; d++) begin
            if (chk_low[d]) begin
               check("valid_after_xfer", d, 32'(act_valid[d]), 32'd0);
               chk_low[d] = 1'b0;
            end
            if (act_valid[d] && instr_ready) begin
               if (exp_q[d].size() == 0) begin
                  check("unexpected_xfer", d, 32'd1, 32'd0);
               end else begin
                  mon_e = exp_q[d].pop_front();
                  check("instr", d, 32'(act_instr[d]), 32'(mon_e));
                  held[d]    = 1'b0;
                  chk_low[d] = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();
      repeat (3) @(posedge clk);
      #1 check_reset("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Basic two-beat load with ready high.
      ready_mode = 1;
      press(8'hA5, 10, 1'b1);
      check_state("t1_b0");
      wait_drain();
      press(8'h3C, 10, 1'b1);
      check_state("t1_b1");
      wait_drain();

      // Short glitches never reach the debounced level.
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1 btn_in = 1'b1;
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #1 btn_in = 1'b0;
         repeat ($urandom_range(1, 3)) @(posedge clk);
      end
      repeat (12) @(posedge clk);
      #1 check_state("t2_glitch");
      press(8'h11, 10, 1'b1);
      check_state("t2_hold");
      wait_drain();
      press(8'h22, 10, 1'b1);
      wait_drain();

      // Overrun while held with ready low.
      ready_mode = 0;
      repeat (2) @(posedge clk);
      press(8'h5A, 10, 1'b1);
      press(8'hC3, 10, 1'b1);
      repeat (20) @(posedge clk);
      #1 check_state("t3_held");
      press(8'h77, 10, 1'b1);
      check_state("t3_ovr");
      ready_mode = 1;
      wait_drain();
      repeat (2) @(posedge clk);
      #1 check_state("t3_after_xfer");
      clr_in = 1'b1;
      @(posedge clk); #1 clr_in = 1'b0;
      model_clear();
      check_state("t3_clr");

      // clr_in during the second press aborts the partial load.
      ready_mode = 2;
      press(8'hFF, 10, 1'b1);
      check_state("t4_b0");
      wait_drain();
      @(posedge clk); #1 clr_in = 1'b1;
      press(8'h99, 10, 1'b0);
      clr_in = 1'b0;
      model_clear();
      check_state("t4_clr");
      press(8'h12, 10, 1'b1);
      wait_drain();
      press(8'h34, 10, 1'b1);
      wait_drain();

      // Asynchronous reset in FILL and in HOLD.
      ready_mode = 0;
      repeat (2) @(posedge clk);
      press(8'h9C, 10, 1'b1);
      @(posedge clk); #3 rst_n = 1'b0;
      #1 check_reset("t6_fill");
      model_clear();
      @(negedge clk); #2 rst_n = 1'b1;
      press(8'hAB, 10, 1'b1);
      press(8'hCD, 10, 1'b1);
      @(posedge clk); #3 rst_n = 1'b0;
      #1 check_reset("t6_hold");
      model_clear();
      @(negedge clk); #2 rst_n = 1'b1;
      ready_mode = 2;
      press(8'h6E, 10, 1'b1);
      wait_drain();
      press(8'hB1, 10, 1'b1);
      wait_drain();

      // Random loads with random hold lengths and random ready.
      for (int k = 0; k < 24; k++) begin
         wait_drain();
         press(8'($urandom), int'($urandom_range(5, 12)), 1'b1);
         check_state("rand");
      end
      wait_drain();
      repeat (4) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
